// File: rtl/cam_capture_ctrl_pkg.sv
// Shared types and default constants for the camera capture controller.
// State encodings are fixed: IDLE=0, ARM=1, CAPTURE=2.
package cam_capture_ctrl_pkg;

   localparam int unsigned PIX_W      = 16;
   localparam int unsigned DEF_WIN_W  = 160;
   localparam int unsigned DEF_WIN_H  = 120;
   localparam int unsigned DEF_ADDR_W = 15;
   localparam int unsigned DEF_CNT_W  = 11;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARM     = 2'd1,
      CAPTURE = 2'd2
   } cap_state_e;

endpackage : cam_capture_ctrl_pkg

// File: rtl/cam_win_counter.sv
// Camera-frame x/y position counters and crop-window qualifier.
// CAM_DECIMATE_EN: only even-x/even-y pixels qualify; window spans 2*WIN_W x 2*WIN_H.
module cam_win_counter
   import cam_capture_ctrl_pkg::*;
#(
   parameter int unsigned WIN_W = DEF_WIN_W,
   parameter int unsigned WIN_H = DEF_WIN_H,
   parameter int unsigned CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             new_pixel,
   input  logic             end_line,
   input  logic [CNT_W-1:0] x_off,
   input  logic [CNT_W-1:0] y_off,
   output logic             in_win_c
);

   localparam int unsigned CMP_W = CNT_W + 1;
`ifdef CAM_DECIMATE_EN
   localparam int unsigned SPAN_X = 2 * WIN_W;
   localparam int unsigned SPAN_Y = 2 * WIN_H;
`else
   localparam int unsigned SPAN_X = WIN_W;
   localparam int unsigned SPAN_Y = WIN_H;
`endif
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0] x_q, x_d;
   logic [CNT_W-1:0] y_q, y_d;
   logic             cand_c;
   logic             in_x_c;
   logic             in_y_c;

   // Saturating position counters; end_line overrides a same-cycle pixel increment
   always_comb begin
      x_d = x_q;
      y_d = y_q;
      if (clr) begin
         x_d = '0;
         y_d = '0;
      end else if (end_line) begin
         x_d = '0;
         if (y_q != CNT_MAX) y_d = y_q + CNT_W'(1);
      end else if (new_pixel) begin
         if (x_q != CNT_MAX) x_d = x_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         x_q <= '0;
         y_q <= '0;
      end else begin
         x_q <= x_d;
         y_q <= y_d;
      end
   end

   // One extra bit keeps offset + span from wrapping
   always_comb begin
`ifdef CAM_DECIMATE_EN
      cand_c = ~x_q[0] & ~y_q[0];
`else
      cand_c = 1'b1;
`endif
      in_x_c = ({1'b0, x_q} >= {1'b0, x_off}) &&
               ({1'b0, x_q} <  ({1'b0, x_off} + CMP_W'(SPAN_X)));
      in_y_c = ({1'b0, y_q} >= {1'b0, y_off}) &&
               ({1'b0, y_q} <  ({1'b0, y_off} + CMP_W'(SPAN_Y)));
      in_win_c = cand_c & in_x_c & in_y_c;
   end

endmodule : cam_win_counter

// File: rtl/cam_capture_ctrl.sv
// Frame-aligned windowed capture of the camera pixel stream into linear frame-buffer writes.
// Optional CAM_DECIMATE_EN (in cam_win_counter) selects 2:1 decimation in both axes.
module cam_capture_ctrl
   import cam_capture_ctrl_pkg::*;
#(
   parameter int unsigned WIN_W  = DEF_WIN_W,
   parameter int unsigned WIN_H  = DEF_WIN_H,
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned CNT_W  = DEF_CNT_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              continuous,
   input  logic              abort,
   input  logic [CNT_W-1:0]  x_off,
   input  logic [CNT_W-1:0]  y_off,
   input  logic              end_frame,
   input  logic              end_line,
   input  logic              new_pixel,
   input  logic [PIX_W-1:0]  pixel,
   output logic              fb_we,
   output logic [ADDR_W-1:0] fb_addr,
   output logic [PIX_W-1:0]  fb_data,
   output logic              busy,
   output logic              frame_done,
   output logic              short_frame,
   output logic [7:0]        frame_cnt
);

   localparam int unsigned    FRAME_PIX = WIN_W * WIN_H;
   localparam int unsigned    PTR_W     = ADDR_W + 1;
   localparam logic [PTR_W-1:0] PTR_FULL = PTR_W'(FRAME_PIX);

   cap_state_e        state_q, state_d;
   logic              cont_q, cont_d;
   logic [CNT_W-1:0]  x_off_q, x_off_d;
   logic [CNT_W-1:0]  y_off_q, y_off_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic              fb_we_q, fb_we_d;
   logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
   logic [PIX_W-1:0]  fb_data_q, fb_data_d;
   logic              busy_q, busy_d;
   logic              frame_done_q, frame_done_d;
   logic              short_frame_q, short_frame_d;
   logic [7:0]        frame_cnt_q, frame_cnt_d;

   logic              in_win_c;
   logic              cnt_clr_c;
   logic              wr_c;
   logic [PTR_W-1:0]  ptr_after_c;

   assign cnt_clr_c = (state_q != CAPTURE) | abort | end_frame;

   cam_win_counter #(
      .WIN_W (WIN_W),
      .WIN_H (WIN_H),
      .CNT_W (CNT_W)
   ) u_win (
      .clk       (clk),
      .rst       (rst),
      .clr       (cnt_clr_c),
      .new_pixel (new_pixel),
      .end_line  (end_line),
      .x_off     (x_off_q),
      .y_off     (y_off_q),
      .in_win_c  (in_win_c)
   );

   // Next-state, write issue and frame bookkeeping
   always_comb begin
      state_d       = state_q;
      cont_d        = cont_q;
      x_off_d       = x_off_q;
      y_off_d       = y_off_q;
      wr_ptr_d      = wr_ptr_q;
      fb_we_d       = 1'b0;
      fb_addr_d     = fb_addr_q;
      fb_data_d     = fb_data_q;
      frame_done_d  = 1'b0;
      short_frame_d = short_frame_q;
      frame_cnt_d   = frame_cnt_q;

      // The pixel is handled before any line/frame update in the same cycle
      wr_c = (state_q == CAPTURE) && !abort && new_pixel && in_win_c &&
             (wr_ptr_q < PTR_FULL);
      ptr_after_c = wr_c ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
      if (wr_c) begin
         fb_we_d   = 1'b1;
         fb_addr_d = ADDR_W'(wr_ptr_q);
         fb_data_d = pixel;
         wr_ptr_d  = ptr_after_c;
      end

      unique case (state_q)
         IDLE: begin
            if (start && !abort) begin
               state_d       = ARM;
               cont_d        = continuous;
               x_off_d       = x_off;
               y_off_d       = y_off;
               short_frame_d = 1'b0;
               frame_cnt_d   = 8'd0;
               wr_ptr_d      = '0;
            end
         end
         ARM: begin
            wr_ptr_d = '0;
            if (abort)          state_d = IDLE;
            else if (end_frame) state_d = CAPTURE;
         end
         CAPTURE: begin
            if (abort) begin
               state_d  = IDLE;
               wr_ptr_d = '0;
            end else if (end_frame) begin
               frame_done_d  = 1'b1;
               frame_cnt_d   = frame_cnt_q + 8'd1;
               short_frame_d = short_frame_q | (ptr_after_c != PTR_FULL);
               wr_ptr_d      = '0;
               state_d       = cont_q ? CAPTURE : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= IDLE;
         cont_q        <= 1'b0;
         x_off_q       <= '0;
         y_off_q       <= '0;
         wr_ptr_q      <= '0;
         fb_we_q       <= 1'b0;
         fb_addr_q     <= '0;
         fb_data_q     <= '0;
         busy_q        <= 1'b0;
         frame_done_q  <= 1'b0;
         short_frame_q <= 1'b0;
         frame_cnt_q   <= 8'd0;
      end else begin
         state_q       <= state_d;
         cont_q        <= cont_d;
         x_off_q       <= x_off_d;
         y_off_q       <= y_off_d;
         wr_ptr_q      <= wr_ptr_d;
         fb_we_q       <= fb_we_d;
         fb_addr_q     <= fb_addr_d;
         fb_data_q     <= fb_data_d;
         busy_q        <= busy_d;
         frame_done_q  <= frame_done_d;
         short_frame_q <= short_frame_d;
         frame_cnt_q   <= frame_cnt_d;
      end
   end

   assign fb_we       = fb_we_q;
   assign fb_addr     = fb_addr_q;
   assign fb_data     = fb_data_q;
   assign busy        = busy_q;
   assign frame_done  = frame_done_q;
   assign short_frame = short_frame_q;
   assign frame_cnt   = frame_cnt_q;

endmodule : cam_capture_ctrl
